// File: rtl/maquina_pkg.sv
// maquina_pkg: definitions shared by the wash, rinse and spin stages of the
// washing-machine controller.
//   estado_t      - 3-bit state encoding used by every stage FSM.
//   TEMPO_*_PAD   - default time constants in clock cycles, so that all stages
//                   count time in the same units.
//   max3()        - elaboration helper used to size timers.
package maquina_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARMADO    = 3'd1,
        ST_ENCHER    = 3'd2,
        ST_AGITAR    = 3'd3,
        ST_DRENAR    = 3'd4,
        ST_ABORTA    = 3'd5,
        ST_CONCLUIDO = 3'd6,
        ST_ERRO      = 3'd7
    } estado_t;

    localparam int TEMPO_ENCHER_PAD = 8;
    localparam int TEMPO_AGITAR_PAD = 6;
    localparam int TEMPO_DRENAR_PAD = 8;
    localparam int NUM_CICLOS_PAD   = 2;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/enxague_temporizador.sv
// temporizador: clear-on-entry saturating cycle counter.
//   clock, reset  - rising-edge clock, asynchronous active-high reset.
//   limpar        - forces the count to 0 on the next edge (state entry).
//   habilitar     - count +1 per cycle while high; holds at all-ones.
//   limite        - compare value for the current state.
//   expirou       - high while the registered count equals limite.
module temporizador #(
    parameter int LARGURA = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               limpar,
    input  logic               habilitar,
    input  logic [LARGURA-1:0] limite,
    output logic               expirou
);

    logic [LARGURA-1:0] contagem_q, contagem_d;

    always_comb begin
        contagem_d = contagem_q;
        if (limpar) begin
            contagem_d = '0;
        end else if (habilitar && (contagem_q != '1)) begin
            // saturate instead of wrapping so a stuck state never re-arms
            // a timeout compare by accident
            contagem_d = contagem_q + {{(LARGURA-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            contagem_q <= '0;
        end else begin
            contagem_q <= contagem_d;
        end
    end

    assign expirou = (contagem_q == limite);

endmodule

// File: rtl/enxague.sv
// enxague: rinse stage of the washing-machine controller.
// Arms when wash activity is seen, starts when the wash stage goes idle with
// start still high, runs NUM_CICLOS fill/agitate/drain cycles under sensor
// control with watchdog timeouts, and flags completion to the spin stage.
//   clock, reset       - rising-edge clock, asynchronous active-high reset.
//   start              - program enable shared with the wash stage.
//   lavagem_ativa      - wash stage activity flag.
//   nivel_cheio/vazio  - drum level sensors.
//   valvula_agua, motor_agitacao, bomba_dreno - actuators (mutually exclusive).
//   enxague_ativo      - high in fill, agitate and drain.
//   enxague_concluido  - rinse finished.
//   erro               - sensor timeout fault, cleared by start low or reset.
//   ciclo_atual        - current rinse cycle, 0-based.
// Every output is a flop loaded from the next-state decode, so outputs match
// the new state in its first cycle and there is no input-to-output path.
module enxague
    import maquina_pkg::*;
#(
    parameter int TEMPO_ENCHER = TEMPO_ENCHER_PAD,
    parameter int TEMPO_AGITAR = TEMPO_AGITAR_PAD,
    parameter int TEMPO_DRENAR = TEMPO_DRENAR_PAD,
    parameter int NUM_CICLOS   = NUM_CICLOS_PAD
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       lavagem_ativa,
    input  logic       nivel_cheio,
    input  logic       nivel_vazio,
    output logic       valvula_agua,
    output logic       motor_agitacao,
    output logic       bomba_dreno,
    output logic       enxague_ativo,
    output logic       enxague_concluido,
    output logic       erro,
    output logic [1:0] ciclo_atual
);

    localparam int TMAX = max3(TEMPO_ENCHER, TEMPO_AGITAR, TEMPO_DRENAR);
    localparam int TW   = $clog2(TMAX) + 1;

    localparam logic [TW-1:0] LIM_ENCHER = TW'(TEMPO_ENCHER - 1);
    localparam logic [TW-1:0] LIM_AGITAR = TW'(TEMPO_AGITAR - 1);
    localparam logic [TW-1:0] LIM_DRENAR = TW'(TEMPO_DRENAR - 1);
    localparam logic [1:0]    ULTIMO     = 2'(NUM_CICLOS - 1);

    estado_t    estado_q, estado_d;
    logic       aborto_q, aborto_d;
    logic [1:0] ciclo_q, ciclo_d;

    logic valvula_q, valvula_d;
    logic motor_q, motor_d;
    logic bomba_q, bomba_d;
    logic ativo_q, ativo_d;
    logic concluido_q, concluido_d;
    logic erro_q, erro_d;

    logic          tmr_limpar;
    logic          tmr_habilitar;
    logic [TW-1:0] tmr_limite;
    logic          tmr_expirou;
    logic          aborto_agora;

    // Timer: cleared whenever the state changes, counts in every timed state.
    assign tmr_limpar    = (estado_d != estado_q);
    assign tmr_habilitar = (estado_q == ST_ENCHER) || (estado_q == ST_AGITAR) ||
                           (estado_q == ST_DRENAR) || (estado_q == ST_ABORTA);

    always_comb begin
        tmr_limite = '0;
        case (estado_q)
            ST_ENCHER:            tmr_limite = LIM_ENCHER;
            ST_AGITAR:            tmr_limite = LIM_AGITAR;
            ST_DRENAR, ST_ABORTA: tmr_limite = LIM_DRENAR;
            default:              tmr_limite = '0;
        endcase
    end

    temporizador #(
        .LARGURA (TW)
    ) u_temporizador (
        .clock     (clock),
        .reset     (reset),
        .limpar    (tmr_limpar),
        .habilitar (tmr_habilitar),
        .limite    (tmr_limite),
        .expirou   (tmr_expirou)
    );

    // A start drop during drain is remembered rather than acted on at once:
    // the drum still has to empty before returning to IDLE.
    assign aborto_agora = aborto_q || !start;

    always_comb begin
        estado_d = estado_q;
        aborto_d = 1'b0;
        ciclo_d  = ciclo_q;
        case (estado_q)
            ST_IDLE: begin
                if (start && lavagem_ativa) estado_d = ST_ARMADO;
            end
            ST_ARMADO: begin
                if (!start) begin
                    estado_d = ST_IDLE;
                end else if (!lavagem_ativa) begin
                    estado_d = ST_ENCHER;
                    ciclo_d  = 2'd0;
                end
            end
            ST_ENCHER: begin
                // level sensor beats the watchdog when both land together
                if (!start)           estado_d = ST_ABORTA;
                else if (nivel_cheio) estado_d = ST_AGITAR;
                else if (tmr_expirou) estado_d = ST_ERRO;
            end
            ST_AGITAR: begin
                if (!start)           estado_d = ST_ABORTA;
                else if (tmr_expirou) estado_d = ST_DRENAR;
            end
            ST_DRENAR: begin
                if (nivel_vazio) begin
                    if (aborto_agora) begin
                        estado_d = ST_IDLE;
                    end else if (ciclo_q < ULTIMO) begin
                        estado_d = ST_ENCHER;
                        ciclo_d  = ciclo_q + 2'd1;
                    end else begin
                        estado_d = ST_CONCLUIDO;
                    end
                end else if (tmr_expirou) begin
                    estado_d = ST_ERRO;
                end else begin
                    aborto_d = aborto_agora;
                end
            end
            ST_ABORTA: begin
                if (nivel_vazio)      estado_d = ST_IDLE;
                else if (tmr_expirou) estado_d = ST_ERRO;
            end
            ST_CONCLUIDO, ST_ERRO: begin
                if (!start) estado_d = ST_IDLE;
            end
            default: estado_d = ST_IDLE;
        endcase
    end

    // Output decode from the next state; one-hot actuator choice by state.
    always_comb begin
        valvula_d   = (estado_d == ST_ENCHER);
        motor_d     = (estado_d == ST_AGITAR);
        bomba_d     = (estado_d == ST_DRENAR) || (estado_d == ST_ABORTA);
        ativo_d     = (estado_d == ST_ENCHER) || (estado_d == ST_AGITAR) ||
                      (estado_d == ST_DRENAR);
        concluido_d = (estado_d == ST_CONCLUIDO);
        erro_d      = (estado_d == ST_ERRO);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q    <= ST_IDLE;
            aborto_q    <= 1'b0;
            ciclo_q     <= 2'd0;
            valvula_q   <= 1'b0;
            motor_q     <= 1'b0;
            bomba_q     <= 1'b0;
            ativo_q     <= 1'b0;
            concluido_q <= 1'b0;
            erro_q      <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            aborto_q    <= aborto_d;
            ciclo_q     <= ciclo_d;
            valvula_q   <= valvula_d;
            motor_q     <= motor_d;
            bomba_q     <= bomba_d;
            ativo_q     <= ativo_d;
            concluido_q <= concluido_d;
            erro_q      <= erro_d;
        end
    end

    assign valvula_agua      = valvula_q;
    assign motor_agitacao    = motor_q;
    assign bomba_dreno       = bomba_q;
    assign enxague_ativo     = ativo_q;
    assign enxague_concluido = concluido_q;
    assign erro              = erro_q;
    assign ciclo_atual       = ciclo_q;

endmodule
